// File: rtl/flex_pkg.sv
// flex_pkg: shared state and mode encodings for the nested flex counter
package flex_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic {WRAP, ONESHOT} mode_e;
endpackage

// File: rtl/flex_counter_stage.sv
// flex_counter_stage: one level of the nest; wraps 0..limit on carry_in
module flex_counter_stage #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] count,
    input  logic [SIZE-1:0] limit,
    input  logic            carry_in,
    input  logic            load_zero,
    output logic [SIZE-1:0] next_count,
    output logic            at_limit,
    output logic            carry_out
);
    // A level at its limit passes the carry outward and returns to zero
    always_comb begin
        at_limit   = count == limit;
        carry_out  = carry_in && at_limit;
        next_count = load_zero ? '0 : !carry_in ? count : at_limit ? '0 : count + SIZE'(1);
    end
endmodule

// File: rtl/nested_flex_counter.sv
// nested_flex_counter: LEVELS cascaded counters forming a nested loop index generator
module nested_flex_counter
    import flex_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int LEVELS = 3
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   count_enable,
    input  logic                   oneshot,
    input  logic [LEVELS*SIZE-1:0] rollover_vals,
    output logic [LEVELS*SIZE-1:0] count_out,
    output logic [LEVELS-1:0]      last,
    output logic                   busy,
    output logic                   done,
    output logic                   wrap_pulse
);
    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [LEVELS*SIZE-1:0]   counts_q, counts_d, limits_q, limits_d, next_counts;
    logic [LEVELS:0]          carry;
    logic [LEVELS-1:0]        at_limit;
    logic                     wrap_q, wrap_d, load_zero, terminal, take_start;

    assign load_zero  = clear || start;
    assign take_start = start && !clear;
    assign carry[0]   = state_q == RUN && count_enable && !load_zero;
    assign terminal   = carry[LEVELS];
    assign count_out  = counts_q;
    assign wrap_pulse = wrap_q;

    for (genvar g = 0; g < LEVELS; g++) begin : g_stage
        flex_counter_stage #(.SIZE(SIZE)) u_stage (
            .count      (counts_q[g*SIZE +: SIZE]),
            .limit      (limits_q[g*SIZE +: SIZE]),
            .carry_in   (carry[g]),
            .load_zero  (load_zero),
            .next_count (next_counts[g*SIZE +: SIZE]),
            .at_limit   (at_limit[g]),
            .carry_out  (carry[g+1])
        );
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: clear beats start beats a terminal one-shot step
    always_comb begin
        state_d = clear ? IDLE : start ? RUN : (terminal && mode_q == ONESHOT) ? DONE : state_q;
    end

    // Next datapath values: a one-shot terminal step freezes counts at their limits
    always_comb begin
        limits_d = take_start ? rollover_vals : limits_q;
        mode_d   = take_start ? mode_e'(oneshot) : mode_q;
        counts_d = (terminal && mode_q == ONESHOT) ? counts_q : next_counts;
        wrap_d   = terminal;
    end

    // Counts, shadows and the wrap pulse register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counts_q <= '0;
            limits_q <= '0;
            mode_q   <= WRAP;
            wrap_q   <= 1'b0;
        end else begin
            counts_q <= counts_d;
            limits_q <= limits_d;
            mode_q   <= mode_d;
            wrap_q   <= wrap_d;
        end
    end

    // Outputs decoded from registers; last is suppressed in IDLE so idle outputs read zero
    always_comb begin
        busy    = state_q == RUN;
        done    = state_q == DONE;
        last[0] = at_limit[0];
        for (int i = 1; i < LEVELS; i++) last[i] = last[i-1] && at_limit[i];
        if (state_q == IDLE) last = '0;
    end
endmodule

// File: doc/nested_flex_counter.md
# nested_flex_counter

Multi-level, parametrised generalisation of the single-level flex counter: LEVELS cascaded SIZE-bit counter stages that form a nested loop index generator (innermost level 0) for the systolic-array controller's row/column/tile sequencing. Rollover limits are latched per run, and each level wraps 0..limit. The block supports free-running wrap mode or one-shot mode with a terminal done state. It sits between the top-level control FSM and the address/enable generators that step operands through the array.

## Interface
- SIZE, 4: bit width of each level's count.
- LEVELS, 3: number of nested levels (≥1); level 0 is innermost.
- clk  input  1  clock; all state updates on its rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear to IDLE, counts zero.
- start  input  1  latch rollover_vals and mode, zero counts, enter RUN.
- count_enable  input  1  advance the nest by one step (effective in RUN only).
- oneshot  input  1  mode sampled at start: 1 = stop at terminal, 0 = wrap.
- rollover_vals  input  LEVELS*SIZE  limit per level; level i at bits [i*SIZE +: SIZE].
- count_out  output  LEVELS*SIZE  current count per level, same packing.
- last  output  LEVELS  last[i] = 1 when levels 0..i all equal their latched limits.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot completion), held.
- wrap_pulse  output  1  one-cycle pulse after a full-nest wrap or entry to DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All outputs reset to 0; limit and mode shadow registers reset to 0.
- Priority per cycle: clear > start > count_enable.
- clear (any state) → IDLE, counts 0, wrap_pulse 0; shadows keep their values.
- start (any state, no clear) → RUN, limits ← rollover_vals, mode ← oneshot, counts 0. A count_enable in the same cycle is ignored.
- RUN with count_enable: level 0 increments; level i (i>0) increments only when levels 0..i-1 are all at their limits. A level at its limit that increments goes to 0. Only this carry chain changes counts; no level skips.
- Full-nest terminal: all levels at limits (last[LEVELS-1]=1) with count_enable asserted:
  - wrap mode: all counts → 0, stay RUN, wrap_pulse next cycle.
  - one-shot: counts hold at limits, → DONE, wrap_pulse next cycle.
- DONE: counts frozen, count_enable ignored; leave only via start, clear, or reset.
- IDLE: counts 0, count_enable ignored.
- Limit 0 on a level: that level stays 0 and is always terminal (pure pass-through carry).
- Arithmetic is unsigned SIZE-bit. Comparison is equality against the latched limit. A count cannot exceed its limit because limits change only at start, when counts are zeroed.
- rollover_vals changes during RUN have no effect.

## Timing
- All outputs are registered or decoded only from registers (state, counts, shadows). No combinational path from inputs to outputs.
- count_out updates the cycle after the qualifying count_enable edge.
- last tracks count_out in the same cycle.
- busy/done are valid the cycle after the causing start/terminal enable.
- wrap_pulse is high exactly one cycle, the cycle after the terminal enable. Back-to-back terminal enables are impossible with any limit > 0. With all limits 0 in wrap mode, wrap_pulse stays high on every enabled cycle.
- Reset asserted mid-run: immediate asynchronous return to IDLE, all outputs 0.

## Structure
- Shared package flex_pkg: state enum (IDLE, RUN, DONE), mode enum (WRAP, ONESHOT).
- Sub-module flex_counter_stage, instantiated LEVELS times via generate. Inputs: count, limit, carry_in, load_zero. Outputs: next_count, at_limit, carry_out.
- Top level holds the FSM, shadow registers, the carry chain, and output registers.

## Test plan
- SIZE=4, LEVELS=3, limits {1,2,3} (L2,L1,L0), wrap mode, 24 enables → count_out returns to 0/0/0; wrap_pulse once, after the 24th enable; last[0] high every 4th step.
- Same limits, one-shot, 30 enables → after the 24th enable, counts hold at 1/2/3, done=1, busy=0, one wrap_pulse; extra enables give no change.
- Limit 0 on L1, limits {2,0,1} → L2 increments every 2 enables; L1 always 0 with last[1]=last[0].
- start with count_enable in the same cycle, then rollover_vals changed mid-run → counts 0 after start; new values ignored until the next start.
- clear and start asserted together in RUN at counts 1/1/1 → IDLE, counts 0, busy=0.
- n_rst pulsed low mid-run between clock edges → all outputs 0 immediately; count_enable ignored until start.
